// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: button indices, keymap entry layout {valid, player, button, ignore-extended, code}, scan FSM states
package arcade_input_pkg;
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_FIRE  = 4;
  localparam int BTN_BOMB  = 5;
  localparam int BTN_START = 6;
  localparam int BTN_COIN  = 7;
  typedef struct packed {
    logic       valid;
    logic [1:0] player;
    logic [2:0] btn;
    logic       ign_ext;
    logic [8:0] code;
  } map_entry_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
  function automatic logic entry_hit(map_entry_t e, logic [8:0] code);
    return e.valid && (e.code == code || (e.ign_ext && e.code[7:0] == code[7:0]));
  endfunction
endpackage

// File: rtl/input_keymap_ram.sv
// input_keymap_ram: DEPTH x 16 keymap; write port (we/waddr/wdata), write-first synchronous read (raddr -> rdata)
module input_keymap_ram #(
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];
  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: ps2_key + keymap write port + joy_in + autofire controls -> registered btn_out per player, busy while scanning
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int MAP_DEPTH    = 32,
  parameter int COIN_PULSE   = 2000000,
  parameter int AUTOFIRE_DIV = 1500000
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic                         map_we,
  input  logic [$clog2(MAP_DEPTH)-1:0] map_addr,
  input  logic [15:0]                  map_data,
  input  logic [16*NUM_PLAYERS-1:0]    joy_in,
  input  logic [7:0]                   autofire_mask,
  input  logic [NUM_PLAYERS-1:0]       autofire_en,
  output logic [8*NUM_PLAYERS-1:0]     btn_out,
  output logic                         busy
);
  localparam int AW = $clog2(MAP_DEPTH);
  localparam int CW = $clog2(COIN_PULSE + 1);
  localparam int FW = $clog2(AUTOFIRE_DIV + 1);
  scan_state_t state;
  logic old_toggle, pending, rd_valid, af_phase, af_wrap, unused_mask;
  logic [9:0] pend_ev, act_ev;
  logic [AW-1:0] idx;
  logic [15:0] rd_data;
  logic [FW-1:0] af_cnt;
  logic [NUM_PLAYERS-1:0][7:0] key_state;
  map_entry_t ent;
  assign ent = map_entry_t'(rd_data);
  assign af_wrap = af_cnt == FW'(AUTOFIRE_DIV - 1);
  assign unused_mask = autofire_mask[BTN_COIN];
  input_keymap_ram #(.DEPTH(MAP_DEPTH)) u_ram (
    .clk_sys,
    .we    (map_we),
    .waddr (map_addr),
    .wdata (map_data),
    .raddr (idx),
    .rdata (rd_data)
  );
  // rd_valid marks the cycle after a SCAN read, when the entry read at idx arrives
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_toggle <= ps2_key[10];
      pending    <= 1'b0;
      pend_ev    <= '0;
      act_ev     <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      rd_valid   <= 1'b0;
      key_state  <= '0;
      state      <= IDLE;
    end else begin
      old_toggle <= ps2_key[10];
      if (ps2_key[10] != old_toggle) begin
        pending <= 1'b1;
        pend_ev <= ps2_key[9:0];
      end else if (state == IDLE && pending) begin
        pending <= 1'b0;
      end
      rd_valid <= state == SCAN;
      for (int p = 0; p < NUM_PLAYERS; p++)
        if (rd_valid && entry_hit(ent, act_ev[8:0]) && ent.player == 2'(p))
          key_state[p][ent.btn] <= act_ev[9];
      case (state)
        IDLE: if (pending) begin
          act_ev <= pend_ev;
          idx    <= '0;
          busy   <= 1'b1;
          state  <= SCAN;
        end
        SCAN: begin
          idx <= idx + 1'b1;
          if (idx == AW'(MAP_DEPTH - 1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else begin
      af_cnt   <= af_wrap ? '0 : af_cnt + 1'b1;
      af_phase <= af_phase ^ af_wrap;
    end
  end
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    logic [7:0] raw, btn_q;
    logic [6:0] af_gate;
    logic raw_coin_d, coin_rise, unused_joy;
    logic [CW-1:0] coin_t;
    assign raw = key_state[g] | joy_in[16*g +: 8];
    assign unused_joy = ^joy_in[16*g+8 +: 8];
    assign af_gate = autofire_en[g] ? autofire_mask[6:0] & {7{~af_phase}} : '0;
    // a rising coin only arms the timer once the stretched output has dropped
    assign coin_rise = raw[BTN_COIN] & ~raw_coin_d & ~btn_q[BTN_COIN];
    assign btn_out[8*g +: 8] = btn_q;
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        raw_coin_d <= 1'b0;
        coin_t     <= '0;
        btn_q      <= '0;
      end else begin
        raw_coin_d <= raw[BTN_COIN];
        coin_t     <= coin_rise ? CW'(COIN_PULSE - 1) : (coin_t != '0) ? coin_t - 1'b1 : coin_t;
        btn_q      <= {raw[BTN_COIN] | (coin_t != '0), raw[6:0] & ~af_gate};
      end
    end
  end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: self-checking bench for arcade_input_mapper
module tb_arcade_input_mapper;
  localparam int NP = 2, MD = 32, CP = 100, AD = 10;
  typedef struct {logic [31:0] joy; logic [15:0] exp; string name;} vec_t;
  logic clk_sys = 1'b0, reset = 1'b1, map_we = 1'b0, busy;
  logic [10:0] ps2_key = 11'h400;
  logic [4:0] map_addr = '0;
  logic [15:0] map_data = '0, btn_out, ks = '0;
  logic [31:0] joy_in = '0;
  logic [7:0] autofire_mask = '0;
  logic [1:0] autofire_en = '0;
  logic [15:0] kmap [MD];
  vec_t vt [8];
  int checks = 0, failures = 0;
  always #5 clk_sys = ~clk_sys;
  arcade_input_mapper #(.NUM_PLAYERS(NP), .MAP_DEPTH(MD), .COIN_PULSE(CP), .AUTOFIRE_DIV(AD)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .map_we(map_we), .map_addr(map_addr),
    .map_data(map_data), .joy_in(joy_in), .autofire_mask(autofire_mask), .autofire_en(autofire_en),
    .btn_out(btn_out), .busy(busy)
  );
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask
  task automatic wr(int a, logic [15:0] d);
    map_addr = 5'(a);
    map_data = d;
    map_we = 1'b1;
    tick();
    map_we = 1'b0;
    kmap[a] = d;
  endtask
  function automatic logic [15:0] ent(bit v, int pl, int b, bit w, logic [8:0] c);
    return {v, 2'(pl), 3'(b), w, c};
  endfunction
  function automatic logic [15:0] rnd_ent();
    return ent(1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), 8'(8'h20 + $urandom_range(0, 3))});
  endfunction
  task automatic key(bit pr, logic [8:0] c);
    ps2_key = {~ps2_key[10], pr, c};
  endtask
  task automatic model_apply(bit pr, logic [8:0] c);
    logic [15:0] m;
    for (int e = 0; e < MD; e++) begin
      m = kmap[e];
      if (m[15] && int'(m[14:13]) < NP && (m[8:0] == c || (m[9] && m[7:0] == c[7:0])))
        ks[8*int'(m[14:13]) + int'(m[12:10])] = pr;
    end
  endtask
  initial begin
    int cnt, cnt1, last, bad, ntr;
    logic prev;
    bit pr;
    logic [8:0] c;
    vt[0] = '{32'h0000_0000, 16'h0000, "merge_zero"};
    vt[1] = '{32'h0000_0001, 16'h0001, "merge_p0_right"};
    vt[2] = '{32'h0010_0000, 16'h1000, "merge_p1_fire"};
    vt[3] = '{32'hFF00_FF00, 16'h0000, "merge_high_ignored"};
    vt[4] = '{32'h006A_0035, 16'h6A35, "merge_mixed"};
    vt[5] = '{32'hAB7F_CD7F, 16'h7F7F, "merge_all_but_coin"};
    vt[6] = '{32'h0040_0000, 16'h4000, "merge_p1_start"};
    vt[7] = '{32'h0000_0000, 16'h0000, "merge_clear"};
    tick(3);
    reset = 1'b0;
    tick(2);
    check("reset_btn", btn_out, 16'h0);
    check("reset_busy", busy, 1'b0);
    for (int e = 0; e < MD; e++) wr(e, 16'h0);
    check("no_spurious_event", busy, 1'b0);
    foreach (vt[i]) begin
      joy_in = vt[i].joy;
      tick();
      check(vt[i].name, btn_out, vt[i].exp);
    end
    // wildcard on extended bit
    wr(0, ent(1, 0, 3, 1, 9'h075));
    key(1, 9'h175);
    tick(4);
    check("t1_lat_early", btn_out[3], 1'b0);
    tick();
    check("t1_lat", btn_out[3], 1'b1);
    tick(31);
    check("t1_press", btn_out, 16'h0008);
    key(0, 9'h075);
    tick(36);
    check("t1_release", btn_out, 16'h0000);
    // two entries, two players, one code
    wr(0, ent(1, 0, 6, 0, 9'h016));
    wr(31, ent(1, 1, 6, 0, 9'h016));
    key(1, 9'h016);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) cnt++;
    end
    check("t2_busy_cycles", cnt, 32);
    check("t2_both_start", btn_out, 16'h4040);
    key(0, 9'h016);
    tick(36);
    check("t2_release", btn_out, 16'h0000);
    // overflow: middle event lost
    wr(1, ent(1, 0, 0, 0, 9'h011));
    wr(2, ent(1, 0, 1, 0, 9'h012));
    wr(3, ent(1, 0, 2, 0, 9'h013));
    key(1, 9'h011);
    tick(5);
    key(1, 9'h012);
    tick(5);
    key(1, 9'h013);
    tick(60);
    check("t3_overflow", btn_out, 16'h0005);
    key(0, 9'h011);
    tick(40);
    key(0, 9'h013);
    tick(40);
    check("t3_release", btn_out, 16'h0000);
    // event on the IDLE->SCAN transfer cycle
    key(1, 9'h011);
    tick();
    key(1, 9'h012);
    tick(80);
    check("t3_transfer_cycle", btn_out, 16'h0003);
    key(0, 9'h011);
    tick(40);
    key(0, 9'h012);
    tick(40);
    check("t3_release2", btn_out, 16'h0000);
    // coin stretch
    joy_in[7] = 1'b1;
    tick();
    joy_in[7] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      if (btn_out[7]) cnt++;
      tick();
    end
    check("t4_coin_pulse", cnt, CP);
    joy_in[7] = 1'b1;
    tick();
    cnt = 0;
    for (int i = 0; i < 450; i++) begin
      if (btn_out[7]) cnt++;
      if (i == 299) joy_in[7] = 1'b0;
      tick();
    end
    check("t4_coin_hold", cnt, 300);
    joy_in[7] = 1'b1;
    tick();
    joy_in[7] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (btn_out[7]) cnt++;
      joy_in[7] = (i == 50);
      tick();
    end
    check("t4_no_retrigger", cnt, CP);
    // autofire
    autofire_mask = 8'h10;
    autofire_en = 2'b01;
    joy_in = 32'h0010_0010;
    tick();
    prev = btn_out[4];
    last = -1;
    bad = 0;
    ntr = 0;
    cnt1 = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (btn_out[12]) cnt1++;
      if (btn_out[4] != prev) begin
        if (last >= 0 && i - last != AD) bad++;
        last = i;
        ntr++;
      end
      prev = btn_out[4];
    end
    check("t5_af_period", bad, 0);
    check("t5_af_toggles", ntr >= 5, 1'b1);
    check("t5_p1_solid", cnt1, 60);
    autofire_mask = 8'h80;
    autofire_en = 2'b11;
    joy_in = 32'h0000_0080;
    tick();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (btn_out[7]) cnt++;
      tick();
    end
    check("t5_coin_solid", cnt, 30);
    joy_in = '0;
    autofire_mask = '0;
    autofire_en = '0;
    tick(120);
    // reset mid-scan
    key(1, 9'h016);
    tick(10);
    check("t6_pre", btn_out, 16'h0040);
    reset = 1'b1;
    key(0, 9'h016);
    tick();
    check("t6_btn", btn_out, 16'h0000);
    check("t6_busy", busy, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(40);
    check("t6_no_event", btn_out, 16'h0000);
    key(1, 9'h016);
    tick(36);
    check("t6_map_kept", btn_out, 16'h4040);
    // randomized against the keymap model
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    ks = '0;
    joy_in = '0;
    tick();
    for (int e = 0; e < MD; e++) wr(e, rnd_ent());
    for (int r = 0; r < 20; r++) begin
      wr($urandom_range(0, MD - 1), rnd_ent());
      joy_in = $urandom;
      pr = 1'($urandom_range(0, 1));
      c = {1'($urandom_range(0, 1)), 8'(8'h20 + $urandom_range(0, 3))};
      key(pr, c);
      model_apply(pr, c);
      tick(140);
      check("rnd_btn", btn_out, ks | {joy_in[23:16], joy_in[7:0]});
      check("rnd_busy", busy, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
